mem_port_arbiter: RTL and testbench

Shares one single-port backing memory between the instruction-cache refill path (burst reads) and the data-memory path (single-word load/store), and generates the matching pipeline stalls. It sits between the IF-stage instruction cache, the MEM-stage data memory interface and the external word-addressed memory. Arbitration is round-robin, and each transaction runs as a beat-by-beat FSM with one beat outstanding.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the memory port arbiter: transaction FSM
//                states, grant identifiers and the default refill burst length.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Words per I-cache line (8 x 32-bit = 256-bit line).
    localparam int unsigned BURST_LEN_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_WAIT = 3'd2,
        D_ADDR = 3'd3,
        D_WAIT = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, word-addressed backing memory between
//                the I-cache refill path (BURST_LEN-word burst reads) and the
//                data path (single-word load/store). Round-robin arbitration,
//                one beat outstanding, and pipeline stall generation.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset            clock; asynchronous active-low reset
//    i_req/i_addr          refill request and line word address
//    i_rvalid/i_rdata      refill word strobe and data, beat order 0..N-1
//    i_done                pulse with the last refill word
//    d_req/d_we/d_addr/    data access request, direction, address and
//    d_wdata               store data
//    d_ack/d_rdata         completion pulse and load data
//    mem_req/mem_we/       beat request to memory, accepted when
//    mem_addr/mem_wdata/   mem_req & mem_ready
//    mem_ready
//    mem_rvalid/mem_rdata  read data return
//    stall_if/stall_mem    combinational pipeline stalls
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    localparam int unsigned      BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state;
    grant_t            last_grant;
    logic [BEAT_W-1:0] beat;

    logic              i_pend;
    logic              d_pend;
    logic              pick_d;
    logic [BEAT_W-1:0] beat_next;
    logic [ADDR_W-1:0] refill_addr0;
    logic [ADDR_W-1:0] refill_addr_next;
    logic              unused_addr_bits;

    // A request whose completion pulse is showing this cycle is finished;
    // masking it keeps the arbiter from re-granting the same request on the
    // edge where the requester is still releasing it.
    assign i_pend    = i_req & ~i_done;
    assign d_pend    = d_req & ~d_ack;
    assign stall_if  = i_pend;
    assign stall_mem = d_pend;

    // Round robin: on a tie the side not granted last time wins.
    assign pick_d = d_pend & (~i_pend | (last_grant == GNT_I));

    assign beat_next        = beat + BEAT_W'(1);
    assign refill_addr0     = {i_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
    assign refill_addr_next = {i_addr[ADDR_W-1:BEAT_W], beat_next};

    // The line offset bits of i_addr are replaced by the beat counter.
    assign unused_addr_bits = ^i_addr[BEAT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            beat       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_done     <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_rvalid <= 1'b0;
            i_done   <= 1'b0;
            d_ack    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state      <= D_ADDR;
                        last_grant <= GNT_D;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                    end else if (i_pend) begin
                        state      <= I_ADDR;
                        last_grant <= GNT_I;
                        beat       <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= refill_addr0;
                    end
                end

                // Bus fields are only reloaded on grant or next beat, so they
                // stay frozen while the memory withholds mem_ready.
                I_ADDR: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= I_WAIT;
                    end
                end

                I_WAIT: begin
                    if (mem_rvalid) begin
                        i_rvalid <= 1'b1;
                        i_rdata  <= mem_rdata;
                        if (beat == LAST_BEAT) begin
                            i_done <= 1'b1;
                            beat   <= '0;
                            state  <= IDLE;
                        end else begin
                            beat     <= beat_next;
                            mem_req  <= 1'b1;
                            mem_addr <= refill_addr_next;
                            state    <= I_ADDR;
                        end
                    end
                end

                // The registered mem_we captured at grant decides store vs load,
                // so a requester changing d_we mid-beat cannot split the access.
                D_ADDR: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            d_ack <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= D_WAIT;
                        end
                    end
                end

                D_WAIT: begin
                    if (mem_rvalid) begin
                        d_ack   <= 1'b1;
                        d_rdata <= mem_rdata;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A behavioural
//                memory (random ready, random read latency) and a reference
//                copy of memory contents provide every expected value.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int BL = 8;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Behavioural memory: 256 words aliased over the address space.
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    beat_t       acc_q[$];

    int          ready_pct = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          bp_left   = 0;
    logic [31:0] bp_addr   = '0;
    int          rv_cyc    = 0;
    int          acc_cyc   = 0;

    initial begin : mem_model
        logic        cap_req, cap_ready, cap_we, pend;
        logic [31:0] cap_addr, cap_wdata, pend_data;
        int          cap_cyc, wait_left;
        cap_req = 0; cap_ready = 0; cap_we = 0; pend = 0;
        cap_addr = '0; cap_wdata = '0; pend_data = '0; cap_cyc = 0; wait_left = 0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (pend) begin
                wait_left--;
                if (wait_left <= 0) begin
                    mem_rvalid = 1'b1; mem_rdata = pend_data; rv_cyc = cyc; pend = 0;
                end
            end
            if (cap_req && cap_ready) begin
                acc_q.push_back('{cap_we, cap_addr, cap_wdata});
                acc_cyc = cap_cyc;
                if (cap_we) mem[idx(cap_addr)] = cap_wdata;
                else begin
                    pend_data = mem[idx(cap_addr)];
                    wait_left = int'($urandom_range(lat_max, lat_min)) - 1;
                    if (wait_left == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = pend_data; rv_cyc = cyc;
                    end else pend = 1;
                end
            end
            // A refused beat must be presented unchanged on the next cycle.
            if (cap_req && !cap_ready && reset)
                chk("bus_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                                {1'b1, cap_we, cap_addr, cap_wdata});
            cap_req = mem_req & reset; cap_we = mem_we;
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_cyc = cyc;
            if (cap_req && bp_left > 0 && mem_addr == bp_addr) begin
                mem_ready = 1'b0; bp_left--;
            end else begin
                mem_ready = (int'($urandom_range(99, 0)) < ready_pct);
            end
            cap_ready = mem_ready;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit last_d = 1'b0;   // reference round-robin state: 1 = data side won last

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_req"},   mem_req,   0);
        chk({tag, "_mem_we"},    mem_we,    0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rvalid"},  i_rvalid,  0);
        chk({tag, "_i_rdata"},   i_rdata,   0);
        chk({tag, "_i_done"},    i_done,    0);
        chk({tag, "_d_ack"},     d_ack,     0);
        chk({tag, "_d_rdata"},   d_rdata,   0);
    endtask

    task automatic refill(input logic [31:0] addr, input bit timed);
        int k, t, n0, e0;
        logic [31:0] base;
        k = 0; t = 0; n0 = acc_q.size(); e0 = cyc;
        base = {addr[31:3], 3'b000};
        i_req = 1'b1; i_addr = addr;
        while (k < BL && t < 400) begin
            tick(); t++;
            if (timed && t == 1) chk("grant_latency", mem_req, 1);
            chk("stall_if", stall_if, !i_done);
            if (i_rvalid) begin
                chk("i_rdata", i_rdata, ref_mem[idx(base + k)]);
                chk("i_rvalid_latency", cyc, rv_cyc + 1);
                chk("i_done_last", i_done, (k == BL - 1));
                k++;
            end else begin
                chk("i_done_alone", i_done, 0);
            end
        end
        chk("refill_words", k, BL);
        if (timed) chk("refill_cycles", cyc - e0, 1 + 2 * BL);
        i_req = 1'b0;
        last_d = 1'b0;
        chk("refill_beats", acc_q.size() - n0, BL);
        for (int j = 0; j < BL; j++)
            if (n0 + j < acc_q.size())
                chk("refill_addr", {acc_q[n0 + j].we, acc_q[n0 + j].addr}, {1'b0, base + j});
    endtask

    task automatic daccess(input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop);
        int acks, t, n0, extra;
        acks = 0; t = 0; n0 = acc_q.size(); extra = 0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        while (acks == 0 && t < 200) begin
            tick(); t++;
            if (!drop) chk("stall_mem", stall_mem, !d_ack);
            if (drop && mem_req) d_req = 1'b0;
            if (d_ack) begin
                acks++;
                chk("d_ack_latency", cyc, (we ? acc_cyc : rv_cyc) + 1);
                if (!we) chk("d_rdata", d_rdata, ref_mem[idx(addr)]);
            end
        end
        chk("d_ack_seen", acks, 1);
        d_req = 1'b0;
        if (we) ref_mem[idx(addr)] = wdata;
        last_d = 1'b1;
        if (drop) begin
            for (int j = 0; j < 6; j++) begin
                tick();
                if (d_ack) extra++;
            end
            chk("d_ack_once", extra, 0);
        end
        chk("d_beats", acc_q.size() - n0, 1);
        if (n0 < acc_q.size()) begin
            chk("d_beat_we_addr", {acc_q[n0].we, acc_q[n0].addr}, {we, addr});
            if (we) chk("d_beat_wdata", acc_q[n0].wdata, wdata);
        end
    endtask

    // Both requesters raised together; the data side optionally keeps its
    // request up after the first ack with a second load (da2).
    task automatic both(input logic [31:0] ia, input logic [31:0] da1, input bit two_d,
                        input logic [31:0] da2, input bit d_first);
        int n0, ik, dn, idn, t, nd;
        logic [31:0] base, exp_a;
        n0 = acc_q.size(); ik = 0; dn = 0; idn = 0; t = 0; nd = two_d ? 2 : 1;
        base = {ia[31:3], 3'b000};
        i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da1;
        while ((dn < nd || idn < 1) && t < 800) begin
            tick(); t++;
            if (i_rvalid) begin
                chk("tie_i_rdata", i_rdata, ref_mem[idx(base + ik)]);
                ik++;
            end
            if (i_done) begin idn++; i_req = 1'b0; end
            if (d_ack) begin
                chk("tie_d_rdata", d_rdata, ref_mem[idx(dn == 0 ? da1 : da2)]);
                dn++;
                if (dn < nd) d_addr = da2;
                else d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("tie_d_acks", dn, nd);
        chk("tie_i_done", idn, 1);
        chk("tie_i_words", ik, BL);
        chk("tie_beats", acc_q.size() - n0, nd + BL);
        for (int j = 0; j < nd + BL; j++) begin
            if (d_first) exp_a = (j == 0) ? da1 : (j <= BL) ? base + (j - 1) : da2;
            else         exp_a = (j < BL) ? base + j : da1;
            if (n0 + j < acc_q.size()) chk("tie_order", acc_q[n0 + j].addr, exp_a);
        end
        last_d = two_d ? 1'b1 : !d_first;
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] v, a, st_addr;
        int t, cnt, op;
        reset = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        st_addr = 32'h0000_0040;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; mem[i] = v; ref_mem[i] = v;
        end
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        // Tie from reset: data first; data keeps requesting, so the repeat
        // tie at its ack goes to the refill, then the second load.
        both(32'h0000_0093, 32'h0000_0011, 1'b1, 32'h0000_0022, 1'b1);
        // Last grant was data: a fresh tie goes to the refill first.
        both(32'h0000_00A5, 32'h0000_0033, 1'b0, '0, 1'b0);

        // Isolated refill with ideal memory, latency checked.
        refill(32'h0000_0013, 1'b1);

        // Store then load the same word.
        daccess(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
        daccess(1'b0, 32'h0000_0040, '0, 1'b0);
        chk("load_deadbeef", d_rdata, 32'hDEAD_BEEF);

        // Backpressure on beat 2.
        bp_addr = 32'h0000_0082; bp_left = 3;
        refill(32'h0000_0085, 1'b0);
        chk("bp_applied", bp_left, 0);

        // Requester drops d_req once granted.
        daccess(1'b0, 32'h0000_0077, '0, 1'b1);

        // Reset during I_WAIT of beat 5, with a late return arriving after.
        lat_min = 3; lat_max = 3;
        i_req = 1'b1; i_addr = 32'h0000_00C0; cnt = 0; t = 0;
        while (cnt < 5 && t < 200) begin
            tick(); t++;
            if (i_rvalid) cnt++;
        end
        chk("pre_reset_words", cnt, 5);
        t = 0;
        while (mem_req && t < 50) begin tick(); t++; end
        chk("in_i_wait", mem_req, 0);
        #1 reset = 1'b0;
        #1 check_reset_values("async_reset");
        i_req = 1'b0;
        tick();
        reset = 1'b1;
        lat_min = 1; lat_max = 1;
        cnt = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            cnt += int'(i_rvalid) + int'(i_done) + int'(mem_req) + int'(d_ack);
        end
        chk("stale_rvalid_ignored", cnt, 0);
        refill(32'h0000_00C3, 1'b1);

        // Randomized traffic against the reference memory and arbiter rule.
        for (int n = 0; n < 30; n++) begin
            ready_pct = int'($urandom_range(100, 40));
            lat_min = 1; lat_max = int'($urandom_range(4, 1));
            op = int'($urandom_range(3, 0));
            a = $urandom;
            case (op)
                0: refill(a, 1'b0);
                1: begin
                       st_addr = a;
                       daccess(1'b1, a, $urandom, 1'b0);
                   end
                2: daccess(1'b0, ($urandom_range(1, 0) != 0) ? st_addr : a, '0, 1'b0);
                default: both(a, $urandom, 1'b0, '0, !last_d);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
